// File: rtl/word_byte_serializer_if.sv
// Word-in / byte-out handshake bundle for word_byte_serializer.
// The master side is the upstream FIFO plus downstream UART; the slave side is the serializer.
interface word_byte_serializer_if;
    logic [31:0] word_in;
    logic [2:0]  num_in;
    logic        word_valid;
    logic        word_ready;
    logic [7:0]  tx_byte;
    logic        tx_dv;
    logic        tx_active;
    logic        tx_done;

    modport master (
        output word_in, num_in, word_valid, tx_active, tx_done,
        input  word_ready, tx_byte, tx_dv
    );

    modport slave (
        input  word_in, num_in, word_valid, tx_active, tx_done,
        output word_ready, tx_byte, tx_dv
    );
endinterface

// File: rtl/word_byte_serializer.sv
// Splits a packed 1..4 byte word into single bytes for a byte UART transmitter,
// with a per-byte tx_done timeout and a running count of completed bytes.
module word_byte_serializer #(
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic                         clk,
    input  logic                         reset,
    word_byte_serializer_if.slave        bus,
    output logic                         busy,
    output logic                         num_err,
    output logic                         timeout,
    output logic [15:0]                  bytes_sent
);
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SEND, WAIT, GAP} state_t;

    state_t        state_q, state_d;
    logic [31:0]   word_q, word_d;
    logic [2:0]    num_q, num_d;
    logic [1:0]    k_q, k_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [7:0]    tx_byte_q, tx_byte_d;
    logic          num_err_q, num_err_d;
    logic          timeout_q, timeout_d;
    logic [15:0]   bytes_sent_q, bytes_sent_d;
    logic          tx_dv_c;

    logic [7:0]    lane_w [4];
    logic [1:0]    lane_sel;

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign lane_w[gi] = word_q[8*gi +: 8];
    end

    // Byte k (k >= 1) of n lives in lane 4-n+k, which is k-n modulo 4.
    assign lane_sel = k_q - num_q[1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            word_q       <= '0;
            num_q        <= '0;
            k_q          <= '0;
            timer_q      <= '0;
            tx_byte_q    <= '0;
            num_err_q    <= 1'b0;
            timeout_q    <= 1'b0;
            bytes_sent_q <= '0;
        end else begin
            state_q      <= state_d;
            word_q       <= word_d;
            num_q        <= num_d;
            k_q          <= k_d;
            timer_q      <= timer_d;
            tx_byte_q    <= tx_byte_d;
            num_err_q    <= num_err_d;
            timeout_q    <= timeout_d;
            bytes_sent_q <= bytes_sent_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        word_d       = word_q;
        num_d        = num_q;
        k_d          = k_q;
        timer_d      = timer_q;
        tx_byte_d    = tx_byte_q;
        num_err_d    = 1'b0;
        timeout_d    = 1'b0;
        bytes_sent_d = bytes_sent_q;
        tx_dv_c      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.word_valid) begin
                    word_d = bus.word_in;
                    num_d  = bus.num_in;
                    k_d    = 2'd0;
                    if (bus.num_in != 3'd0 && bus.num_in <= 3'd4) begin
                        state_d   = SEND;
                        tx_byte_d = bus.word_in[7:0];
                    end else begin
                        num_err_d = 1'b1;
                    end
                end
            end
            SEND: begin
                if (!bus.tx_active) begin
                    tx_dv_c = 1'b1;
                    timer_d = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // tx_done takes priority over a timer expiring in the same cycle.
                if (bus.tx_done) begin
                    bytes_sent_d = bytes_sent_q + 16'd1;
                    k_d          = k_q + 2'd1;
                    state_d      = (({1'b0, k_q} + 3'd1) < num_q) ? GAP : IDLE;
                end else if (timer_q == TIMER_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            GAP: begin
                tx_byte_d = lane_w[lane_sel];
                state_d   = SEND;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.word_ready = (state_q == IDLE);
    assign bus.tx_byte    = tx_byte_q;
    assign bus.tx_dv      = tx_dv_c;
    assign busy           = (state_q != IDLE);
    assign num_err        = num_err_q;
    assign timeout        = timeout_q;
    assign bytes_sent     = bytes_sent_q;
endmodule
